ztonxor_gen: RTL
================

// Module: ztonxor_gen
// PURPOSE
//  Producer of the ztonxor bit consumed by the endpoint-register stage.
//  Holds a DEPTH-bit data array, loaded one bit per write.
//  On request, serially computes the prefix XOR data[0]^...^data[q_idx], one bit per cycle.
//  Presents the result as ztonxor with a valid/busy handshake.
//  The sequencer sets the matching inst (SETL/SETR) on the consumer in the cycle ztonxor_valid is high.
// PARAMETERS
//  DEPTH  16  number of data bits held (>=2)
//  IDXW   4   index width, = clog2(DEPTH)
// PORTS
//  clk            in   1     system clock, all state on rising edge
//  reset          in   1     synchronous, active-high; clears all state
//  wr_en          in   1     write data[wr_addr] <= wr_bit this cycle
//  wr_addr        in   IDXW  write address; values >= DEPTH ignored
//  wr_bit         in   1     write data
//  q_start        in   1     request prefix XOR over [0..q_idx]
//  q_idx          in   IDXW  inclusive end index of request
//  busy           out  1     scan in progress; new requests and writes ignored
//  ztonxor        out  1     last computed prefix XOR, held stable until next result
//  ztonxor_valid  out  1     one-cycle pulse: ztonxor just updated
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - data array all 0, FSM=IDLE, acc=0, cnt=0
//   - busy=0, ztonxor=0, ztonxor_valid=0
//   - reset asserted mid-scan aborts the scan; no valid pulse is issued
//  FSM states: IDLE, SCAN, DONE.
//  IDLE:
//   - q_start=1 latches end=min(q_idx, DEPTH-1), cnt=0, acc=0 -> SCAN
//   - if wr_en and q_start are both high, the write commits first; the scan sees the new bit
//  SCAN:
//   - each cycle acc<=acc^data[cnt]
//   - if cnt==end -> DONE, else cnt<=cnt+1
//  DONE (one cycle):
//   - ztonxor<=acc, ztonxor_valid=1 -> IDLE
//  busy=1 in SCAN and DONE; valid pulse is registered in the DONE cycle.
//  Latency: q_start sampled at edge N; ztonxor_valid high in cycle N+end+2; ztonxor updated same cycle.
//  Back-to-back: q_start may be reasserted in the cycle after DONE (IDLE); throughput = end+3 cycles per query.
//  q_start or wr_en while busy=1: silently dropped; the array and the running scan are unaffected.
//  q_idx >= DEPTH (when DEPTH < 2^IDXW): clamped to DEPTH-1.
//  wr_addr >= DEPTH: the write is dropped.
//  ztonxor keeps its value through IDLE and SCAN; it changes only on a DONE cycle or on reset.
//  acc and the result are single bits; no counts and no overflow.
// TESTING
//  1 After reset, no writes; q_start, q_idx=5:
//    -> busy for 7 cycles; valid pulse at start+7; ztonxor=0.
//  2 Write data=16'b0000_0000_0010_1101 (bits 0,2,3,5); q_idx=3 -> ztonxor=1.
//    Then q_idx=5 -> ztonxor=0.
//    Then q_idx=15 -> ztonxor=0, valid at start+17.
//  3 During a q_idx=15 scan: pulse q_start with q_idx=0, and wr_en addr=0 bit=1.
//    -> single valid pulse only, result unchanged by the write.
//    A follow-up query of q_idx=0 returns data[0] from before the dropped write.
//  4 Write and q_start in the same IDLE cycle (addr 0, bit 1, q_idx=0)
//    -> ztonxor=1 at start+2.
//  5 Reset raised 3 cycles into a q_idx=10 scan:
//    -> busy=0, ztonxor=0, no valid pulse.
//    The array reads back all 0 on subsequent queries.
//  6 DEPTH=12, IDXW=4: q_idx=15 behaves as q_idx=11 (valid at start+13).
//    A write to addr 13 is ignored.

Source files
------------

// File: rtl/ztonxor_gen.sv
// ztonxor_gen: holds a DEPTH-bit data array written one bit at a time and,
// on request, serially computes the prefix XOR data[0]^...^data[end] one bit
// per cycle. The result is presented on ztonxor with a one-cycle valid pulse.
module ztonxor_gen #(
    parameter int DEPTH = 16,
    parameter int IDXW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_addr,
    input  logic            wr_bit,
    input  logic            q_start,
    input  logic [IDXW-1:0] q_idx,
    output logic            busy,
    output logic            ztonxor,
    output logic            ztonxor_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Highest legal index, used to clamp out-of-range query ends.
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    state_t            state_r;
    state_t            state_s;
    logic [DEPTH-1:0]  data_r;
    logic [IDXW-1:0]   cnt_r;
    logic [IDXW-1:0]   cnt_s;
    logic [IDXW-1:0]   end_r;
    logic [IDXW-1:0]   end_s;
    logic              acc_r;
    logic              acc_s;
    logic              busy_r;
    logic              busy_s;
    logic              res_r;
    logic              valid_r;
    logic              res_load_s;
    logic              wr_ok_s;
    logic              addr_ok_s;
    logic              idx_over_s;

    // One XOR accumulation step of the running prefix parity.
    function automatic logic parity_step(input logic acc, input logic bit_in);
        parity_step = acc ^ bit_in;
    endfunction

    // Range checks are done one bit wider so they stay meaningful when DEPTH == 2**IDXW.
    always_comb begin
        addr_ok_s  = ({1'b0, wr_addr} < (IDXW + 1)'(DEPTH));
        idx_over_s = ({1'b0, q_idx} >= (IDXW + 1)'(DEPTH));
    end

    // Next-state and datapath decisions; writes are only accepted while idle.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        end_s      = end_r;
        acc_s      = acc_r;
        busy_s     = busy_r;
        res_load_s = 1'b0;
        wr_ok_s    = 1'b0;
        case (state_r)
            IDLE: begin
                wr_ok_s = wr_en & addr_ok_s;
                if (q_start) begin
                    end_s   = idx_over_s ? LAST_IDX : q_idx;
                    cnt_s   = {IDXW{1'b0}};
                    acc_s   = 1'b0;
                    busy_s  = 1'b1;
                    state_s = SCAN;
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            SCAN: begin
                acc_s  = parity_step(acc_r, data_r[cnt_r]);
                busy_s = 1'b1;
                if (cnt_r == end_r) begin
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r + IDXW'(1);
                    state_s = SCAN;
                end
            end
            DONE: begin
                res_load_s = 1'b1;
                busy_s     = 1'b0;
                state_s    = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, scan counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {IDXW{1'b0}};
            end_r   <= {IDXW{1'b0}};
            acc_r   <= 1'b0;
            busy_r  <= 1'b0;
            res_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            end_r   <= end_s;
            acc_r   <= acc_s;
            busy_r  <= busy_s;
            valid_r <= res_load_s;
            if (res_load_s) begin
                res_r <= acc_r;
            end
        end
    end

    // Data array: one bit per accepted write; out-of-range addresses never match.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok_s && (wr_addr == IDXW'(i))) begin
                    data_r[i] <= wr_bit;
                end
            end
        end
    end

    assign busy          = busy_r;
    assign ztonxor       = res_r;
    assign ztonxor_valid = valid_r;

endmodule
